// File: rtl/spu_pkg.sv
// Shared SPU definitions: datapath widths and the result-pipeline entry record.
// Used by the FX units and by the register file.
package spu_pkg;

   // Register file geometry: 128 registers of 128 bits.
   localparam int SPU_DATA_W = 128;
   localparam int SPU_RT_W   = 7;

   // Highest pipeline depth the FX1 result pipe is built for.
   localparam int FX1_MAX_LATENCY = 6;

   // One in-flight result: data uses big-endian indexing, bit 0 is the MSB.
   typedef struct packed {
      logic                  valid;
      logic [SPU_RT_W-1:0]   rt;
      logic [0:SPU_DATA_W-1] data;
   } fx1_entry_t;

   // Reset value of a stage: invalid, zero address, zero data.
   localparam fx1_entry_t FX1_ENTRY_EMPTY = {1'b0, {SPU_RT_W{1'b0}}, {SPU_DATA_W{1'b0}}};

   // Kill an entry but keep its payload; rt/data of an invalid entry are don't-care.
   function automatic fx1_entry_t fx1_entry_kill(input fx1_entry_t e);
      fx1_entry_t k;
      k       = e;
      k.valid = 1'b0;
      return k;
   endfunction

endpackage

// File: rtl/fx1_pipe_stage.sv
// One FX1 result-pipeline stage: a single fx1_entry_t register.
// Flush clears the valid bit and takes priority over stall; stall holds the entry;
// otherwise the stage captures its upstream entry.
module fx1_pipe_stage
   import spu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stall_i,
   input  logic       flush_i,
   input  fx1_entry_t d_i,
   output fx1_entry_t q_o
);

   fx1_entry_t entry_d;
   fx1_entry_t entry_q;

   // Next-state selection: flush beats stall beats normal advance.
   always_comb begin
      entry_d = entry_q;
      if (flush_i) begin
         entry_d = fx1_entry_kill(entry_q);
      end else if (stall_i) begin
         entry_d = entry_q;
      end else begin
         entry_d = d_i;
      end
   end

   // Stage register with asynchronous clear to an empty entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q <= FX1_ENTRY_EMPTY;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign q_o = entry_q;

endmodule

// File: rtl/fx1_result_pipe.sv
// FX1 result pipeline: delays FX1 results and their destination tags by LATENCY
// register stages on the way to the register-file write port, with stall (hold)
// and flush (kill). The wb_* outputs come straight from the last stage register.
// Optional feature macro FX1_FWD_EN: adds a combinational operand lookup
// (fwd_addr -> fwd_hit/fwd_data) over all in-flight stages, youngest match first.
// LATENCY legal range is 1..FX1_MAX_LATENCY (6).
module fx1_result_pipe
   import spu_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int DATA_W  = SPU_DATA_W,
   parameter int RT_W    = SPU_RT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [RT_W-1:0]   ex_rt,
   input  logic [0:DATA_W-1] ex_result,
   input  logic              stall,
   input  logic              flush,
`ifdef FX1_FWD_EN
   input  logic [RT_W-1:0]   fwd_addr,
   output logic              fwd_hit,
   output logic [0:DATA_W-1] fwd_data,
`endif
   output logic              wb_valid,
   output logic [RT_W-1:0]   wb_rt,
   output logic [0:DATA_W-1] wb_data,
   output logic              busy
);

   fx1_entry_t ex_entry_s;
   fx1_entry_t stage_q_s [LATENCY];
   logic       busy_s;

   // Bundle the execute-stage outputs into the entry captured by stage 0.
   always_comb begin
      ex_entry_s       = FX1_ENTRY_EMPTY;
      ex_entry_s.valid = ex_valid;
      ex_entry_s.rt    = ex_rt;
      ex_entry_s.data  = ex_result;
   end

   // Lock-step chain: stage 0 takes the ex entry, stage k takes stage k-1.
   // Bubbles travel down the chain unchanged; nothing collapses.
   for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      if (k == 0) begin : g_head
         fx1_pipe_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall_i (stall),
            .flush_i (flush),
            .d_i     (ex_entry_s),
            .q_o     (stage_q_s[k])
         );
      end else begin : g_body
         fx1_pipe_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall_i (stall),
            .flush_i (flush),
            .d_i     (stage_q_s[k-1]),
            .q_o     (stage_q_s[k])
         );
      end
   end

   // Pipeline occupancy: OR of every stage valid bit.
   always_comb begin
      busy_s = 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
         if (stage_q_s[k].valid) begin
            busy_s = 1'b1;
         end else begin
            busy_s = busy_s;
         end
      end
   end

   assign busy     = busy_s;
   assign wb_valid = stage_q_s[LATENCY-1].valid;
   assign wb_rt    = stage_q_s[LATENCY-1].rt;
   assign wb_data  = stage_q_s[LATENCY-1].data;

`ifdef FX1_FWD_EN
   logic              fwd_hit_s;
   logic [0:DATA_W-1] fwd_data_s;

   // Priority lookup: scan oldest to youngest so the lowest-index match wins.
   // A stage held at the wb output by a stall still takes part.
   always_comb begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = {DATA_W{1'b0}};
      for (int k = LATENCY - 1; k >= 0; k--) begin
         if (stage_q_s[k].valid && (stage_q_s[k].rt == fwd_addr)) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = stage_q_s[k].data;
         end else begin
            fwd_hit_s  = fwd_hit_s;
            fwd_data_s = fwd_data_s;
         end
      end
   end

   assign fwd_hit  = fwd_hit_s;
   assign fwd_data = fwd_data_s;
`endif

endmodule
